// File: rtl/abc.sv
// abc: sampling and classification unit.
// Starts the X and Y converters together, waits for both results, and then
// reports whether the signed point (x, y) lies in the closed annulus
// 2500 <= x^2 + y^2 <= 4096. The one-bit verdict goes to the consumer over
// a dav_/rfd handshake, and the block then loops back for the next sample.
module abc (
  input  logic       clock,
  input  logic       reset_,
  output logic       soc_x,
  input  logic       eoc_x,
  input  logic [7:0] x,
  output logic       soc_y,
  input  logic       eoc_y,
  input  logic [7:0] y,
  output logic       dav_,
  input  logic       rfd,
  output logic       z
);

  // S0 idle, S1 start requested, S2 converting, S3 compute, S4 handshake
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state_q;

  // One start register drives both converters; they are always started together.
  logic              soc_q;
  logic              dav_n_q;
  logic              z_q;
  logic signed [7:0] x_q;
  logic signed [7:0] y_q;

  // Squares are formed at 16 bits: the largest, (-128)^2 = 16384, fits, and
  // truncating the 16x16 product to 16 bits is exact because the true
  // result is non-negative and below 2^16.
  logic signed [15:0] x_ext;
  logic signed [15:0] y_ext;
  logic signed [15:0] sq_x;
  logic signed [15:0] sq_y;
  logic        [16:0] sum_sq;
  logic               in_annulus_d;

  // Radius-squared of the captured point and the inclusive range test.
  always_comb begin
    x_ext        = {{8{x_q[7]}}, x_q};
    y_ext        = {{8{y_q[7]}}, y_q};
    sq_x         = x_ext * x_ext;
    sq_y         = y_ext * y_ext;
    // A spare top bit keeps the (-128,-128) case, 32768, from wrapping.
    sum_sq       = {1'b0, sq_x} + {1'b0, sq_y};
    in_annulus_d = (sum_sq >= 17'd2500) && (sum_sq <= 17'd4096);
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S0;
      soc_q   <= 1'b0;
      dav_n_q <= 1'b1;
      z_q     <= 1'b0;
      x_q     <= 8'sd0;
      y_q     <= 8'sd0;
    end else begin
      case (state_q)
        S0: begin
          soc_q   <= 1'b0;
          dav_n_q <= 1'b1;
          // Only start when both converters are idle and the consumer can
          // accept a result.
          if (eoc_x && eoc_y && rfd) begin
            soc_q   <= 1'b1;
            state_q <= S1;
          end
        end
        S1: begin
          // Hold the request until both converters acknowledge in the same
          // cycle; a converter that drops eoc early simply waits.
          if (!eoc_x && !eoc_y) begin
            soc_q   <= 1'b0;
            state_q <= S2;
          end
        end
        S2: begin
          // Converters may finish in either order; capture only when both
          // report done so neither sample is taken mid-conversion.
          if (eoc_x && eoc_y) begin
            x_q     <= x;
            y_q     <= y;
            state_q <= S3;
          end
        end
        S3: begin
          // z and dav_ change on the same edge so the consumer can take z
          // at the falling edge of dav_.
          z_q     <= in_annulus_d;
          dav_n_q <= 1'b0;
          state_q <= S4;
        end
        S4: begin
          if (!rfd) begin
            dav_n_q <= 1'b1;
            state_q <= S0;
          end
        end
        default: begin
          soc_q   <= 1'b0;
          dav_n_q <= 1'b1;
          state_q <= S0;
        end
      endcase
    end
  end

  assign soc_x = soc_q;
  assign soc_y = soc_q;
  assign dav_  = dav_n_q;
  assign z     = z_q;

endmodule

// File: tb/tb_abc.sv
// Directed testbench for abc: behavioural X/Y converters with programmable
// latencies, a consumer driven from the test tasks, and hand-computed
// annulus verdicts for each test point.
module tb_abc;

  logic       clock = 1'b0;
  logic       reset_;
  logic       soc_x, eoc_x, soc_y, eoc_y;
  logic [7:0] x, y;
  logic       dav_, rfd, z;

  int checks   = 0;
  int failures = 0;

  // Converter model controls: cycles from seeing soc to dropping eoc, and
  // cycles from dropping eoc to finishing.
  int xd = 1, yd = 1, xc = 1, yc = 1;
  logic signed [7:0] x_val = 8'sd40;
  logic signed [7:0] y_val = 8'sd40;
  int xs = 0, ys = 0, xcnt = 0, ycnt = 0;
  int dav_falls = 0;

  // Base points; indices 0-5 are inside the annulus, 6-15 outside.
  int tx [16] = '{40, 10, 50, 64,  0, 50,  0, 32, 50, 48,  0, 49, 64, -128,    0, -128};
  int ty [16] = '{40, 50, 10,  0, 64,  0,  0, 32, 50,  0, 48,  0,  1,    0, -128, -128};
  bit tz [16] = '{ 1,  1,  1,  1,  1,  1,  0,  0,  0,  0,  0,  0,  0,    0,    0,    0};

  abc dut (
    .clock (clock),
    .reset_(reset_),
    .soc_x (soc_x),
    .eoc_x (eoc_x),
    .x     (x),
    .soc_y (soc_y),
    .eoc_y (eoc_y),
    .y     (y),
    .dav_  (dav_),
    .rfd   (rfd),
    .z     (z)
  );

  always #5 clock = ~clock;

  always @(negedge dav_) if (reset_) dav_falls++;

  // X converter: outputs junk (127) while converting, finishes only after soc drops.
  always @(negedge clock) begin
    case (xs)
      0: if (soc_x) begin xcnt = xd; xs = 1; end
      1: if (xcnt <= 1) begin eoc_x = 1'b0; x = 8'd127; xcnt = xc; xs = 2; end
         else xcnt--;
      2: if (xcnt > 1) xcnt--;
         else if (!soc_x) begin eoc_x = 1'b1; x = x_val; xs = 0; end
      default: xs = 0;
    endcase
  end

  // Y converter, same behaviour with its own latencies.
  always @(negedge clock) begin
    case (ys)
      0: if (soc_y) begin ycnt = yd; ys = 1; end
      1: if (ycnt <= 1) begin eoc_y = 1'b0; y = 8'd127; ycnt = yc; ys = 2; end
         else ycnt--;
      2: if (ycnt > 1) ycnt--;
         else if (!soc_y) begin eoc_y = 1'b1; y = y_val; ys = 0; end
      default: ys = 0;
    endcase
  end

  task automatic wait_dav_low(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (dav_ === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ack(output bit ok);
    rfd = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (dav_ === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_conv(input logic signed [7:0] xv, input logic signed [7:0] yv,
                         output logic zo, output bit ok);
    bit ok1, ok2;
    @(negedge clock);
    x_val = xv; y_val = yv; rfd = 1'b1;
    wait_dav_low(ok1);
    zo = z;
    ack(ok2);
    ok = ok1 & ok2;
  endtask

  task automatic test_reset();
    bit ok;
    x_val = 8'sd40; y_val = 8'sd40;
    xd = 1; yd = 1; xc = 2; yc = 2;
    reset_ = 1'b0; rfd = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (soc_x !== 1'b0) begin failures++; $display("FAIL reset_soc_x got=%b want=0", soc_x); end
    checks++; if (soc_y !== 1'b0) begin failures++; $display("FAIL reset_soc_y got=%b want=0", soc_y); end
    checks++; if (dav_ !== 1'b1) begin failures++; $display("FAIL reset_dav got=%b want=1", dav_); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b want=0", z); end
    reset_ = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (soc_x !== 1'b1 || soc_y !== 1'b1) begin
      failures++; $display("FAIL reset_first_soc got=%b%b want=11", soc_x, soc_y);
    end
    wait_dav_low(ok);
    checks++;
    if (!ok || z !== 1'b1) begin failures++; $display("FAIL reset_first_z ok=%0b got=%b want=1", ok, z); end
    ack(ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_first_ack dav_ did not rise got=%b want=1", dav_); end
    $display("reset: done");
  endtask

  task automatic test_skew();
    bit ok;
    int f0, drops, bad;
    logic ex, ey, sx;
    xd = 1; yd = 2; xc = 2; yc = 4;
    f0 = dav_falls; drops = 0; bad = 0; ok = 1'b0;
    @(negedge clock);
    x_val = 8'sd10; y_val = -8'sd50; rfd = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1; ex = eoc_x; ey = eoc_y; sx = soc_x;
      @(posedge clock); #1;
      if (sx && !soc_x) begin drops++; if (ex || ey) bad++; end
      @(negedge clock);
      if (dav_ === 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || z !== 1'b1) begin failures++; $display("FAIL skew_z ok=%0b got=%b want=1", ok, z); end
    checks++;
    if (drops != 1 || bad != 0) begin
      failures++; $display("FAIL skew_soc_drop drops=%0d early=%0d want drops=1 early=0", drops, bad);
    end
    ack(ok);
    checks++;
    if (!ok || dav_falls - f0 != 1) begin
      failures++; $display("FAIL skew_dav_pulses got=%0d want=1 ack_ok=%0b", dav_falls - f0, ok);
    end
    $display("skew: (10,-50) drops=%0d pulses=%0d", drops, dav_falls - f0);
  endtask

  task automatic test_inside();
    logic zo; bit ok;
    logic signed [7:0] xv, yv;
    xd = 1; yd = 1; xc = 2; yc = 3;
    for (int b = 0; b < 6; b++) begin
      for (int s = 0; s < 4; s++) begin
        xv = 8'(s[0] ? -tx[b] : tx[b]);
        yv = 8'(s[1] ? -ty[b] : ty[b]);
        do_conv(xv, yv, zo, ok);
        checks++;
        if (!ok || zo !== tz[b]) begin
          failures++; $display("FAIL inside (%0d,%0d) ok=%0b got=%b want=%b", xv, yv, ok, zo, tz[b]);
        end
        $display("inside: (%0d,%0d) z=%b", xv, yv, zo);
      end
    end
  endtask

  task automatic test_outside();
    logic zo; bit ok;
    logic signed [7:0] xv, yv;
    xd = 2; yd = 1; xc = 3; yc = 1;
    for (int b = 6; b < 16; b++) begin
      for (int s = 0; s < 4; s++) begin
        xv = 8'(s[0] ? -tx[b] : tx[b]);
        yv = 8'(s[1] ? -ty[b] : ty[b]);
        do_conv(xv, yv, zo, ok);
        checks++;
        if (!ok || zo !== tz[b]) begin
          failures++; $display("FAIL outside (%0d,%0d) ok=%0b got=%b want=%b", xv, yv, ok, zo, tz[b]);
        end
        $display("outside: (%0d,%0d) z=%b", xv, yv, zo);
      end
    end
  endtask

  task automatic test_slow_consumer();
    bit ok;
    int bad;
    xd = 1; yd = 1; xc = 2; yc = 2;
    @(negedge clock);
    x_val = -8'sd40; y_val = 8'sd40; rfd = 1'b1;
    wait_dav_low(ok);
    checks++;
    if (!ok || z !== 1'b1) begin failures++; $display("FAIL slow_z ok=%0b got=%b want=1", ok, z); end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (dav_ !== 1'b0 || z !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL slow_hold unstable_cycles=%0d want=0", bad); end
    rfd = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (dav_ !== 1'b1) begin failures++; $display("FAIL slow_dav_rise got=%b want=1", dav_); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (soc_x !== 1'b0 || soc_y !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL slow_no_soc soc_cycles=%0d want=0", bad); end
    rfd = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (soc_x !== 1'b1 || soc_y !== 1'b1) begin
      failures++; $display("FAIL slow_restart got=%b%b want=11", soc_x, soc_y);
    end
    wait_dav_low(ok);
    ack(ok);
    checks++;
    if (!ok || z !== 1'b1) begin failures++; $display("FAIL slow_second ok=%0b got=%b want=1", ok, z); end
    $display("slow_consumer: (-40,40) held 30 cycles");
  endtask

  task automatic test_reset_s2();
    logic zo; bit ok, seen;
    xd = 1; yd = 1; xc = 2; yc = 2;
    do_conv(8'sd40, 8'sd40, zo, ok);
    checks++;
    if (!ok || zo !== 1'b1) begin failures++; $display("FAIL rst_s2_pre ok=%0b got=%b want=1", ok, zo); end
    xc = 20; yc = 20;
    @(negedge clock);
    x_val = 8'sd0; y_val = 8'sd0; rfd = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (soc_x === 1'b1) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    ok = 1'b0;
    for (int c = 0; c < 20 && seen; c++) begin
      @(negedge clock);
      if (soc_x === 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_s2_reach soc_seen=%0b soc_dropped=%0b want=1", seen, ok); end
    repeat (2) @(negedge clock);
    reset_ = 1'b0; #1;
    checks++;
    if (soc_x !== 1'b0 || soc_y !== 1'b0 || dav_ !== 1'b1 || z !== 1'b0) begin
      failures++; $display("FAIL rst_s2_outputs soc=%b%b dav_=%b z=%b want soc=00 dav_=1 z=0", soc_x, soc_y, dav_, z);
    end
    x_val = 8'sd10; y_val = 8'sd50; xc = 2; yc = 2;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    do_conv(8'sd10, 8'sd50, zo, ok);
    checks++;
    if (!ok || zo !== 1'b1) begin failures++; $display("FAIL rst_s2_after ok=%0b got=%b want=1", ok, zo); end
    $display("reset_s2: after (10,50) z=%b", zo);
  endtask

  task automatic test_reset_s4();
    logic zo; bit ok;
    xd = 1; yd = 2; xc = 1; yc = 2;
    @(negedge clock);
    x_val = 8'sd0; y_val = 8'sd64; rfd = 1'b1;
    wait_dav_low(ok);
    checks++;
    if (!ok || z !== 1'b1) begin failures++; $display("FAIL rst_s4_pre ok=%0b got=%b want=1", ok, z); end
    repeat (5) @(negedge clock);
    reset_ = 1'b0; #1;
    checks++;
    if (soc_x !== 1'b0 || soc_y !== 1'b0 || dav_ !== 1'b1 || z !== 1'b0) begin
      failures++; $display("FAIL rst_s4_outputs soc=%b%b dav_=%b z=%b want soc=00 dav_=1 z=0", soc_x, soc_y, dav_, z);
    end
    x_val = -8'sd50; y_val = -8'sd10;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    do_conv(-8'sd50, -8'sd10, zo, ok);
    checks++;
    if (!ok || zo !== 1'b1) begin failures++; $display("FAIL rst_s4_after ok=%0b got=%b want=1", ok, zo); end
    $display("reset_s4: after (-50,-10) z=%b", zo);
  endtask

  task automatic test_back_to_back();
    logic zo; bit ok;
    int b, s, f0;
    logic signed [7:0] xv, yv;
    for (int i = 0; i < 64; i++) begin
      b = i % 16; s = (i / 16) % 4;
      xd = 1 + i % 3; yd = 1 + (i / 3) % 3;
      xc = 1 + i % 4; yc = 1 + (i * 7) % 5;
      xv = 8'(s[0] ? -tx[b] : tx[b]);
      yv = 8'(s[1] ? -ty[b] : ty[b]);
      f0 = dav_falls;
      do_conv(xv, yv, zo, ok);
      checks++;
      if (!ok || zo !== tz[b] || dav_falls - f0 != 1) begin
        failures++;
        $display("FAIL soak[%0d] (%0d,%0d) ok=%0b got=%b want=%b pulses=%0d want=1",
                 i, xv, yv, ok, zo, tz[b], dav_falls - f0);
      end
      $display("soak[%0d]: (%0d,%0d) z=%b", i, xv, yv, zo);
    end
  endtask

  initial begin
    eoc_x = 1'b1; eoc_y = 1'b1;
    x = 8'd0; y = 8'd0;
    rfd = 1'b1; reset_ = 1'b0;
    test_reset();
    test_skew();
    test_inside();
    test_outside();
    test_slow_consumer();
    test_reset_s2();
    test_reset_s4();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/abc.md
# abc

Sampling and classification unit. It runs two 8-bit converters, X and Y, through a shared start/end-of-conversion handshake. It treats the two readings as a signed point (x, y) and reports whether the point lies in the annulus 2500 ≤ x²+y² ≤ 4096. The 1-bit result goes to a downstream consumer over a dav_/rfd handshake, and the block then loops forever.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on the rising edge
- reset_  in  1  reset, asynchronous and active-low
- soc_x  out  1  start-of-conversion request to the X converter
- eoc_x  in  1  end-of-conversion from X; 1 = idle/done, 0 = converting
- x  in  8  X sample, two's complement; valid while eoc_x = 1 after a conversion
- soc_y  out  1  start-of-conversion request to the Y converter
- eoc_y  in  1  end-of-conversion from Y; same meaning as eoc_x
- y  in  8  Y sample, two's complement
- dav_  out  1  data-available to the consumer, active-low
- rfd  in  1  ready-for-data from the consumer; 1 = ready
- z  out  1  classification result; valid whenever dav_ = 0

## Operation
- **Reset.** Asynchronous, active-low. While asserted:
  - soc_x = soc_y = 0, dav_ = 1, z = 0
  - internal X/Y registers = 0
  - state = S0
- **S0 (idle).**
  - Hold soc_x = soc_y = 0 and dav_ = 1.
  - When eoc_x = 1, eoc_y = 1 and rfd = 1: set soc_x = soc_y = 1 and go to S1.
  - Otherwise stay in S0.
- **S1 (start requested).**
  - Keep both soc at 1.
  - When eoc_x = 0 and eoc_y = 0 in the same sampled cycle: set soc_x = soc_y = 0 and go to S2.
  - If one converter drops eoc earlier than the other, keep waiting; soc stays 1 until both are low.
- **S2 (waiting for results).**
  - When eoc_x = 1 and eoc_y = 1: register X ← x and Y ← y on that edge, then go to S3.
  - The converters may finish in either order.
- **S3 (compute).**
  - S = X·X + Y·Y, using signed 8×8 products. Each square is ≤ 16384 and S ≤ 32768, so a 16-bit unsigned sum holds it with no overflow.
  - Set z = 1 if 2500 ≤ S ≤ 4096, else z = 0. Both bounds are inclusive.
  - Register z, set dav_ = 0, go to S4.
  - The arithmetic may be combinational within this one cycle.
- **S4 (output handshake).**
  - Hold dav_ = 0 and z stable.
  - When rfd = 0: set dav_ = 1 and go to S0.
  - S0 then waits for rfd = 1 before starting the next conversion.
- **Reset mid-operation.** Aborts any state immediately and drives the reset values, including soc = 0 and dav_ = 1. A pending z is discarded.
- z holds its last value after dav_ returns to 1, until the next S3.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- First soc rise is 1 clock after reset release, provided eoc_x = eoc_y = rfd = 1.
- Latency from sampling X/Y (S2 exit) to dav_ falling: 1 clock (the S3 cycle). z is valid on the same edge as dav_ falls.
- The consumer must be able to sample z at the falling edge of dav_.
- dav_ rises 1 clock after rfd = 0 is sampled.
- The next soc rises no earlier than 1 clock after rfd = 1 is sampled in S0.
- Converter response times are arbitrary and may differ between X and Y. The block must not time out.

## Test plan
- **Reset.** Assert reset_ = 0 with eoc_x = eoc_y = rfd = 1 -> soc_x = soc_y = 0, dav_ = 1, z = 0. Release -> soc_x and soc_y rise on the next clock.
- **Skewed converters.** X converter answers after 1 cycle, Y after 2 cycles.
  - soc drops only after both eoc are low.
  - X/Y are sampled only after both eoc are high.
  - Exactly one dav_ pulse per conversion.
- **Inside-annulus points** (expect z = 1 at dav_ falling edge):
  - (40,40), (10,50), (50,10), (64,0), (0,64)
  - The same points with x negated, y negated, and both negated.
- **Outside-annulus points** (expect z = 0):
  - (0,0), (32,32), (50,50), (48,0), (0,48), with all sign variants
  - (−128,0), (0,−128), (−128,−128), where S = 32768 must not overflow
- **Slow consumer.** Hold rfd = 1 for many cycles after dav_ falls.
  - dav_ stays 0 and z stays stable until rfd = 0.
  - After dav_ rises, no new soc until rfd returns to 1.
- **Mid-operation reset.** Assert reset_ during S2 and again during S4 -> outputs return to reset values immediately, and the next full cycle produces a correct z.
- **Soak.** Run 64 back-to-back conversions with the sequence above -> every z matches the expected value.
